// File: rtl/mc_ctrl_fsm_if.sv
// rtl/mc_ctrl_fsm_if.sv - instruction-field / control-strobe bundle between datapath and mc_ctrl_fsm
// Perf counter signals are present only when MC_CTRL_PERF_EN is defined.
interface mc_ctrl_fsm_if;
    logic [1:0] op;
    logic [5:0] funct;
    logic [3:0] rd;
    logic       cond_ex;
    logic       mem_ready;

    logic       ir_write;
    logic       adr_src;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] result_src;
    logic       alu_op;
    logic       reg_w;
    logic       mem_w;
    logic       pc_write;
    logic       illegal;
`ifdef MC_CTRL_PERF_EN
    logic [31:0] cyc_cnt;
    logic [31:0] instr_cnt;
    logic [31:0] stall_cnt;
`endif

    modport master (
        output op, funct, rd, cond_ex, mem_ready,
        input  ir_write, adr_src, alu_src_a, alu_src_b, result_src,
        input  alu_op, reg_w, mem_w, pc_write, illegal
`ifdef MC_CTRL_PERF_EN
        , input cyc_cnt, instr_cnt, stall_cnt
`endif
    );

    modport slave (
        input  op, funct, rd, cond_ex, mem_ready,
        output ir_write, adr_src, alu_src_a, alu_src_b, result_src,
        output alu_op, reg_w, mem_w, pc_write, illegal
`ifdef MC_CTRL_PERF_EN
        , output cyc_cnt, instr_cnt, stall_cnt
`endif
    );
endinterface

// File: rtl/mc_ctrl_fsm.sv
// rtl/mc_ctrl_fsm.sv - multi-cycle ARM main control FSM with PC-write qualification
// Optional cycle/instruction/stall counters enabled by MC_CTRL_PERF_EN.
module mc_ctrl_fsm #(
    parameter int         ST_W    = 4,
    parameter logic [3:0] R15_IDX = 4'd15
) (
    input  logic         clk,
    input  logic         rst_n,
    mc_ctrl_fsm_if.slave bus
);

    typedef enum logic [ST_W-1:0] {
        RST_W,
        FETCH,
        DECODE,
        MEMADR,
        MEMRD,
        MEMWB,
        MEMWR,
        EXER,
        EXEI,
        ALUWB,
        BRANCH
    } state_t;

    state_t state_q, state_d;
    logic   illegal_q, illegal_d;

    // funct[2:1] only matters to the ALU decoder, not to sequencing
    logic unused_funct;
    assign unused_funct = ^bus.funct[2:1];

    logic rd_is_pc;
    logic alu_writes;
    assign rd_is_pc   = (bus.rd == R15_IDX);
    assign alu_writes = bus.cond_ex & (bus.funct[4:3] != 2'b10);

    always_comb begin
        state_d   = state_q;
        illegal_d = illegal_q;
        case (state_q)
            RST_W:  state_d = FETCH;
            FETCH:  if (bus.mem_ready) state_d = DECODE;
            DECODE: begin
                case (bus.op)
                    2'b01:   state_d = MEMADR;
                    2'b00:   state_d = bus.funct[5] ? EXEI : EXER;
                    2'b10:   state_d = BRANCH;
                    default: begin
                        state_d   = FETCH;
                        illegal_d = 1'b1;
                    end
                endcase
            end
            MEMADR: state_d = bus.funct[0] ? MEMRD : MEMWR;
            MEMRD:  if (bus.mem_ready) state_d = MEMWB;
            MEMWB:  state_d = FETCH;
            MEMWR:  if (bus.mem_ready) state_d = FETCH;
            EXER:   state_d = ALUWB;
            EXEI:   state_d = ALUWB;
            ALUWB:  state_d = FETCH;
            BRANCH: state_d = FETCH;
            default: state_d = RST_W;
        endcase
    end

`ifdef MC_CTRL_PERF_EN
    logic [31:0] cyc_cnt_q;
    logic [31:0] instr_cnt_q;
    logic [31:0] stall_cnt_q;
    logic        stall_state;
    assign stall_state = (state_q == FETCH) || (state_q == MEMRD) || (state_q == MEMWR);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= RST_W;
            illegal_q <= 1'b0;
`ifdef MC_CTRL_PERF_EN
            cyc_cnt_q   <= 32'd0;
            instr_cnt_q <= 32'd0;
            stall_cnt_q <= 32'd0;
`endif
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
`ifdef MC_CTRL_PERF_EN
            if (state_q != RST_W)
                cyc_cnt_q <= cyc_cnt_q + 32'd1;
            if ((state_q == FETCH) && bus.mem_ready)
                instr_cnt_q <= instr_cnt_q + 32'd1;
            if (stall_state && !bus.mem_ready)
                stall_cnt_q <= stall_cnt_q + 32'd1;
`endif
        end
    end

    // Moore decode of the state register; only mem_ready/cond_ex/rd/funct qualify strobes
    always_comb begin
        bus.ir_write   = 1'b0;
        bus.adr_src    = 1'b0;
        bus.alu_src_a  = 1'b0;
        bus.alu_src_b  = 2'b00;
        bus.result_src = 2'b00;
        bus.alu_op     = 1'b0;
        bus.reg_w      = 1'b0;
        bus.mem_w      = 1'b0;
        bus.pc_write   = 1'b0;
        case (state_q)
            FETCH: begin
                bus.alu_src_a  = 1'b1;
                bus.alu_src_b  = 2'b10;
                bus.result_src = 2'b10;
                bus.ir_write   = bus.mem_ready;
                bus.pc_write   = bus.mem_ready;
            end
            DECODE: begin
                bus.alu_src_a  = 1'b1;
                bus.alu_src_b  = 2'b10;
                bus.result_src = 2'b10;
            end
            MEMADR: bus.alu_src_b = 2'b01;
            MEMRD:  bus.adr_src   = 1'b1;
            MEMWB: begin
                bus.result_src = 2'b01;
                bus.reg_w      = bus.cond_ex;
                bus.pc_write   = bus.cond_ex & rd_is_pc;
            end
            MEMWR: begin
                bus.adr_src = 1'b1;
                bus.mem_w   = bus.cond_ex;
            end
            EXER: bus.alu_op = 1'b1;
            EXEI: begin
                bus.alu_op    = 1'b1;
                bus.alu_src_b = 2'b01;
            end
            ALUWB: begin
                bus.reg_w    = alu_writes;
                bus.pc_write = alu_writes & rd_is_pc;
            end
            BRANCH: begin
                bus.alu_src_b  = 2'b01;
                bus.result_src = 2'b10;
                bus.pc_write   = bus.cond_ex;
            end
            default: ;
        endcase
    end

    assign bus.illegal = illegal_q;
`ifdef MC_CTRL_PERF_EN
    assign bus.cyc_cnt   = cyc_cnt_q;
    assign bus.instr_cnt = instr_cnt_q;
    assign bus.stall_cnt = stall_cnt_q;
`endif

endmodule
